// File: rtl/boid_frame_sched_if.sv
// Scheduler-side bundle: frame tick/overrun control in, memory/datapath strobes out.
// master = the scheduler itself, slave = its consumers (VGA timing, memory, datapath).
interface boid_frame_sched_if #(
   parameter int IW        = 2,
   parameter int WB_CYCLES = 7
);
   logic                 frame_tick;
   logic                 clr_overrun;
   logic [IW-1:0]        which_boid;
   logic                 rd_en;
   logic [IW-1:0]        rd_addr;
   logic                 rd_self;
   logic                 dp_clr;
   logic                 dp_en;
   logic [WB_CYCLES-1:0] wb_en;
   logic                 busy;
   logic                 done;
   logic                 overrun;
   logic [15:0]          frame_cnt;

   modport master (
      input  frame_tick, clr_overrun,
      output which_boid, rd_en, rd_addr, rd_self, dp_clr, dp_en, wb_en,
             busy, done, overrun, frame_cnt
   );

   modport slave (
      output frame_tick, clr_overrun,
      input  which_boid, rd_en, rd_addr, rd_self, dp_clr, dp_en, wb_en,
             busy, done, overrun, frame_cnt
   );
endinterface

// File: rtl/boid_frame_sched.sv
// Frame scheduler: one O(N^2) boid update pass per frame tick
// (LOAD self, SCAN neighbours, DRAIN, WB strobes, NEXT boid, DONE).
module boid_frame_sched #(
   parameter int          NUM_BOIDS     = 2,
   parameter int          WB_CYCLES     = 7,
   parameter int          IW            = $clog2(NUM_BOIDS) + 1,
   parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
   input  logic               clk,
   input  logic               reset,
   boid_frame_sched_if.master bus
);
   localparam int            WW        = $clog2(WB_CYCLES + 1);
   localparam logic [IW-1:0] LAST_BOID = IW'(NUM_BOIDS - 1);
   localparam logic [IW-1:0] LAST_SCAN = IW'(NUM_BOIDS - 2);
   localparam logic [WW-1:0] LAST_WB   = WW'(WB_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_WB, S_NEXT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] which_q, which_d;
   logic [IW-1:0] nbr_q, nbr_d, nbr_step;
   logic [IW-1:0] scan_q, scan_d;
   logic [WW-1:0] wb_q, wb_d;
   logic          dp_en_q;
   logic          overrun_q;
   logic [15:0]   frame_cnt_q;

   // Neighbour index after the current one, hopping over the self boid.
   always_comb begin
      nbr_step = nbr_q + 1'b1;
      if (nbr_step == which_q) nbr_step = nbr_q + IW'(2);
   end

   always_comb begin
      state_d     = state_q;
      which_d     = which_q;
      nbr_d       = nbr_q;
      scan_d      = scan_q;
      wb_d        = wb_q;
      bus.rd_en   = 1'b0;
      bus.rd_self = 1'b0;
      bus.rd_addr = '0;
      bus.dp_clr  = 1'b0;
      bus.wb_en   = '0;
      bus.done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_tick) begin
               which_d = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            bus.rd_en   = 1'b1;
            bus.rd_self = 1'b1;
            bus.rd_addr = which_q;
            bus.dp_clr  = 1'b1;
            nbr_d       = (which_q == '0) ? IW'(1) : '0;
            scan_d      = '0;
            state_d     = S_SCAN;
         end
         S_SCAN: begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = nbr_q;
            nbr_d       = nbr_step;
            scan_d      = scan_q + 1'b1;
            if (scan_q == LAST_SCAN) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            wb_d    = '0;
            state_d = S_WB;
         end
         S_WB: begin
            bus.wb_en = WB_CYCLES'(1) << wb_q;
            wb_d      = wb_q + 1'b1;
            if (wb_q == LAST_WB) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (which_q == LAST_BOID) begin
               which_d = '0;
               state_d = S_DONE;
            end else begin
               which_d = which_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory data lands one cycle after each SCAN read, hence the delayed dp_en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         which_q     <= '0;
         nbr_q       <= '0;
         scan_q      <= '0;
         wb_q        <= '0;
         dp_en_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= FRAME_CNT_RST;
      end else begin
         state_q <= state_d;
         which_q <= which_d;
         nbr_q   <= nbr_d;
         scan_q  <= scan_d;
         wb_q    <= wb_d;
         dp_en_q <= (state_q == S_SCAN);
         if (state_q == S_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (bus.frame_tick && (state_q != S_IDLE)) overrun_q <= 1'b1;
         else if (bus.clr_overrun)                  overrun_q <= 1'b0;
      end
   end

   assign bus.which_boid = which_q;
   assign bus.dp_en      = dp_en_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.overrun    = overrun_q;
   assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_boid_frame_sched.sv
// Scoreboard bench for boid_frame_sched: expected per-cycle outputs of each pass are
// queued from a behavioural model before the tick and popped as the DUT runs.
module tb_boid_frame_sched;
   localparam int WB = 7;

   logic clk = 1'b0;
   logic reset_a, reset_b;
   always #5 clk = ~clk;

   boid_frame_sched_if #(.IW(2), .WB_CYCLES(WB)) bus_a ();
   boid_frame_sched_if #(.IW(3), .WB_CYCLES(WB)) bus_b ();

   boid_frame_sched #(.NUM_BOIDS(2), .WB_CYCLES(WB)) dut_a (
      .clk(clk), .reset(reset_a), .bus(bus_a)
   );
   boid_frame_sched #(.NUM_BOIDS(4), .WB_CYCLES(WB), .FRAME_CNT_RST(16'hFFFF)) dut_b (
      .clk(clk), .reset(reset_b), .bus(bus_b)
   );

   typedef struct packed {
      logic        busy, done, rd_en, rd_self, dp_clr, dp_en, ovr;
      logic [7:0]  addr, which;
      logic [15:0] wb, fc;
   } smp_t;

   smp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_fc_a = 16'h0000, exp_fc_b = 16'hFFFF;
   logic        exp_ovr_a = 1'b0, exp_ovr_b = 1'b0;

   function automatic smp_t samp(input bit use_b);
      smp_t s;
      if (use_b) begin
         s = '{busy: bus_b.busy, done: bus_b.done, rd_en: bus_b.rd_en, rd_self: bus_b.rd_self,
               dp_clr: bus_b.dp_clr, dp_en: bus_b.dp_en, ovr: bus_b.overrun,
               addr: 8'(bus_b.rd_addr), which: 8'(bus_b.which_boid),
               wb: 16'(bus_b.wb_en), fc: bus_b.frame_cnt};
      end else begin
         s = '{busy: bus_a.busy, done: bus_a.done, rd_en: bus_a.rd_en, rd_self: bus_a.rd_self,
               dp_clr: bus_a.dp_clr, dp_en: bus_a.dp_en, ovr: bus_a.overrun,
               addr: 8'(bus_a.rd_addr), which: 8'(bus_a.which_boid),
               wb: 16'(bus_a.wb_en), fc: bus_a.frame_cnt};
      end
      return s;
   endfunction

   function automatic string fmt(input smp_t s);
      return $sformatf("busy=%0b done=%0b rd=%0b self=%0b clr=%0b dp=%0b ovr=%0b addr=%0d which=%0d wb=%h fc=%h",
                       s.busy, s.done, s.rd_en, s.rd_self, s.dp_clr, s.dp_en, s.ovr,
                       s.addr, s.which, s.wb, s.fc);
   endfunction

   function automatic smp_t base(input int c, input int b, input int ovr_at,
                                 input logic ovr0, input logic [15:0] fc0);
      smp_t e = '0;
      e.busy  = 1'b1;
      e.which = 8'(b);
      e.fc    = fc0;
      e.ovr   = (ovr_at > 0 && c > ovr_at) ? 1'b1 : ovr0;
      return e;
   endfunction

   // Expected outputs for cycles 1..L of a pass plus the first IDLE cycle after it.
   task automatic gen_exp(input int n, input int ovr_at, input logic [15:0] fc0, input logic ovr0);
      smp_t e;
      int   c = 1;
      bit   first;
      for (int b = 0; b < n; b++) begin
         e = base(c, b, ovr_at, ovr0, fc0);
         e.rd_en = 1'b1; e.rd_self = 1'b1; e.dp_clr = 1'b1; e.addr = 8'(b);
         exp_q.push_back(e); c++;
         first = 1'b1;
         for (int j = 0; j < n; j++) begin
            if (j != b) begin
               e = base(c, b, ovr_at, ovr0, fc0);
               e.rd_en = 1'b1; e.addr = 8'(j); e.dp_en = !first;
               first = 1'b0;
               exp_q.push_back(e); c++;
            end
         end
         e = base(c, b, ovr_at, ovr0, fc0);
         e.dp_en = 1'b1;
         exp_q.push_back(e); c++;
         for (int k = 0; k < WB; k++) begin
            e = base(c, b, ovr_at, ovr0, fc0);
            e.wb = 16'(1) << k;
            exp_q.push_back(e); c++;
         end
         e = base(c, b, ovr_at, ovr0, fc0);
         exp_q.push_back(e); c++;
      end
      e = base(c, 0, ovr_at, ovr0, fc0);
      e.done = 1'b1;
      exp_q.push_back(e); c++;
      e = '0;
      e.fc  = fc0 + 16'd1;
      e.ovr = (ovr_at > 0 && c > ovr_at) ? 1'b1 : ovr0;
      exp_q.push_back(e);
   endtask

   task automatic drive_tick(input bit use_b, input logic v);
      if (use_b) bus_b.frame_tick = v; else bus_a.frame_tick = v;
   endtask

   task automatic drive_clr(input bit use_b, input logic v);
      if (use_b) bus_b.clr_overrun = v; else bus_a.clr_overrun = v;
   endtask

   // Tick is raised in the caller's current cycle (cycle 0); compares cycles 1..L+1.
   task automatic run_pass(input bit use_b, input int ovr_at, input bit clr_too,
                           input bit chain, input string name);
      smp_t got, exp;
      int   len;
      gen_exp(use_b ? 4 : 2, ovr_at, use_b ? exp_fc_b : exp_fc_a, use_b ? exp_ovr_b : exp_ovr_a);
      len = exp_q.size();
      exp = '0;
      drive_tick(use_b, 1'b1);
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         if (c == 1) drive_tick(use_b, 1'b0);
         if (ovr_at > 0 && c == ovr_at + 1) begin
            drive_tick(use_b, 1'b0);
            drive_clr(use_b, 1'b0);
         end
         got = samp(use_b);
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got {%s} expected {%s}", name, c, fmt(got), fmt(exp));
         end
         if (c == ovr_at) begin
            drive_tick(use_b, 1'b1);
            if (clr_too) drive_clr(use_b, 1'b1);
         end
         if (c == len && chain) drive_tick(use_b, 1'b1);
      end
      if (use_b) begin exp_fc_b = exp.fc; exp_ovr_b = exp.ovr; end
      else       begin exp_fc_a = exp.fc; exp_ovr_a = exp.ovr; end
      $display("[TB] pass %s dut=%s cycles=%0d frame_cnt=%h overrun=%0b",
               name, use_b ? "n4" : "n2", len - 1, exp.fc, exp.ovr);
   endtask

   task automatic clear_overrun_a(input string name);
      @(negedge clk); bus_a.clr_overrun = 1'b1;
      @(negedge clk); bus_a.clr_overrun = 1'b0;
      n_tests++;
      if (bus_a.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL %s overrun got %0b expected 0", name, bus_a.overrun);
      end
      exp_ovr_a = 1'b0;
   endtask

   task automatic test_reset;
      smp_t got, exp_b;
      reset_a = 1'b0; reset_b = 1'b0;
      repeat (3) @(negedge clk);
      reset_a = 1'b1; reset_b = 1'b1;
      exp_b = '0; exp_b.fc = 16'hFFFF;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         got = samp(1'b0); n_tests++;
         if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_a cycle=%0d got {%s} expected all zero", c, fmt(got));
         end
         got = samp(1'b1); n_tests++;
         if (got !== exp_b) begin
            n_fail++;
            $display("FAIL reset_idle_b cycle=%0d got {%s} expected {%s}", c, fmt(got), fmt(exp_b));
         end
      end
      $display("[TB] reset: 10 idle cycles observed");
   endtask

   task automatic test_single_pass;
      run_pass(1'b0, 0, 1'b0, 1'b0, "single_pass");
   endtask

   task automatic test_overrun;
      run_pass(1'b0, 5, 1'b0, 1'b0, "overrun_tick5");
      for (int c = 25; c <= 31; c++) begin
         @(negedge clk);
         if (c == 30) begin
            n_tests++;
            if (bus_a.overrun !== 1'b1) begin
               n_fail++;
               $display("FAIL overrun_sticky got %0b expected 1", bus_a.overrun);
            end
            bus_a.clr_overrun = 1'b1;
         end
         if (c == 31) begin
            bus_a.clr_overrun = 1'b0;
            n_tests++;
            if (bus_a.overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL overrun_clear got %0b expected 0", bus_a.overrun);
            end
         end
      end
      exp_ovr_a = 1'b0;
      $display("[TB] overrun cleared at cycle 31");
   endtask

   task automatic test_set_wins;
      run_pass(1'b0, 5, 1'b1, 1'b0, "set_beats_clear");
      clear_overrun_a("clear_after_set_wins");
   endtask

   task automatic test_done_tick;
      run_pass(1'b0, 23, 1'b0, 1'b0, "tick_in_done");
      clear_overrun_a("clear_after_done_tick");
   endtask

   task automatic test_back_to_back;
      run_pass(1'b0, 0, 1'b0, 1'b1, "back_to_back_1");
      run_pass(1'b0, 0, 1'b0, 1'b0, "back_to_back_2");
   endtask

   task automatic test_mid_reset;
      smp_t got;
      bus_a.frame_tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) bus_a.frame_tick = 1'b0;
      end
      reset_a = 1'b0;
      #1;
      got = samp(1'b0); n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_async got {%s} expected all zero", fmt(got));
      end
      @(negedge clk);
      got = samp(1'b0); n_tests++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_held got {%s} expected all zero", fmt(got));
      end
      reset_a = 1'b1;
      exp_fc_a = 16'h0000; exp_ovr_a = 1'b0;
      $display("[TB] reset asserted at cycle 12 of a pass");
      run_pass(1'b0, 0, 1'b0, 1'b0, "after_mid_reset");
   endtask

   task automatic test_n4_wrap;
      run_pass(1'b1, 0, 1'b0, 1'b0, "n4_wrap");
   endtask

   initial begin
      bus_a.frame_tick = 1'b0; bus_a.clr_overrun = 1'b0;
      bus_b.frame_tick = 1'b0; bus_b.clr_overrun = 1'b0;
      test_reset;
      test_single_pass;
      test_overrun;
      test_set_wins;
      test_done_tick;
      test_back_to_back;
      test_mid_reset;
      test_n4_wrap;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before the test sequence completed");
      $fatal(1, "watchdog");
   end
endmodule
